// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
package fetch_pkg;
  localparam int FETCH_XLEN = 64;
  localparam int FETCH_ILEN = FETCH_XLEN / 2;
  localparam logic [FETCH_ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ILEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO of {instr, pc} entries with head and
// second-entry read ports. DEPTH must be a power of two so pointers wrap freely.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  fetch_entry_t          wdata,
  output fetch_entry_t          head,
  output logic [FETCH_ILEN-1:0] second_instr,
  output logic [CW-1:0]         count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
  logic [CW-1:0] count_q, count_d;

  assign rd_nxt       = rd_ptr_q + AW'(1);
  assign head         = mem_q[rd_ptr_q];
  assign second_instr = mem_q[rd_nxt].instr;
  assign count        = count_q;

  // Next-state: flush wins over push/pop; push and pop together keep count.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_nxt;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fetch_cycle.sv
// fetch_cycle: instruction-fetch stage. Owns the PC, issues in-order imem
// requests, buffers returned words and hands the head word to decode.
// Redirects flush the buffer and kill in-flight responses.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky
// flag and block requests until an aligned redirect arrives.
// XLEN/INSTRUCTION_LENGTH must match the fetch_pkg entry widths.
module fetch_cycle
  import fetch_pkg::*;
#(
  parameter int               XLEN               = FETCH_XLEN,
  parameter int               INSTRUCTION_LENGTH = XLEN / 2,
  parameter logic [XLEN-1:0]  RESET_PC           = '0,
  parameter int               FIFO_DEPTH         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_resp_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] imem_resp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          f_to_d_enable_ff,
  output logic                          instr_valid,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic [INSTRUCTION_LENGTH-1:0] next_instruction,
  output logic [INSTRUCTION_LENGTH-1:0] instruction_direct,
  output logic [XLEN-1:0]               PC_out,
  output logic                          fetch_misaligned
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, tgt_pc;
  logic [CW-1:0] out_q, out_d, kill_q, kill_d, count;
  logic [INSTRUCTION_LENGTH-1:0] direct_q, direct_d, second_instr;
  logic mis_q, mis_d;
  logic push, pop, accept;
  logic [CW:0] occ;
  fetch_entry_t wentry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt_pc = redirect_pc;
`else
  assign tgt_pc = redirect_pc & ~XLEN'(3);
`endif

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & f_to_d_enable_ff & ~redirect_valid;
  assign push        = imem_resp_valid & (kill_q == '0) & ~redirect_valid;
  // A head leaving this cycle frees its slot, which keeps 1 word/cycle going.
  assign occ            = (CW+1)'(out_q) + (CW+1)'(count) - (CW+1)'(pop);
  assign imem_req_valid = (state_q != IDLE) & ~redirect_valid & ~mis_q &
                          (occ < (CW+1)'(FIFO_DEPTH));
  assign accept         = imem_req_valid & imem_req_ready;
  assign imem_req_addr  = fetch_pc_q;

  assign wentry.instr = imem_resp_data;
  assign wentry.pc    = resp_pc_q;

  fetch_buffer #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .pop         (pop),
    .flush       (redirect_valid),
    .wdata       (wentry),
    .head        (head),
    .second_instr(second_instr),
    .count       (count)
  );

  assign instruction        = instr_valid ? head.instr : NOP_INSTR;
  assign PC_out             = instr_valid ? head.pc : '0;
  assign next_instruction   = (count >= CW'(2)) ? second_instr : NOP_INSTR;
  assign instruction_direct = direct_q;
  assign fetch_misaligned   = mis_q;

  // PC, outstanding/kill counters and misalign flag; redirect takes priority.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CW'(accept) - CW'(imem_resp_valid);
    kill_d     = kill_q;
    direct_d   = push ? imem_resp_data : NOP_INSTR;
    mis_d      = mis_q;
    if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (push)   resp_pc_d  = resp_pc_q + XLEN'(4);
    if (redirect_valid) begin
      fetch_pc_d = tgt_pc;
      resp_pc_d  = tgt_pc;
      kill_d     = out_q - CW'(imem_resp_valid);
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d      = |redirect_pc[1:0];
`endif
    end else if (imem_resp_valid && (kill_q != '0)) begin
      kill_d = kill_q - CW'(1);
    end
  end

  // FSM next state: FLUSH lasts while stale responses remain to be dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (redirect_valid && (kill_d != '0)) state_d = FLUSH;
      FLUSH:   if (kill_d == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      kill_q     <= '0;
      direct_q   <= NOP_INSTR;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      kill_q     <= kill_d;
      direct_q   <= direct_d;
      mis_q      <= mis_d;
    end
  end
endmodule
